// File: rtl/ieee754_divider.sv
// Multi-cycle IEEE-754 binary32 divider: radix-2 restoring mantissa division,
// one quotient bit per clock, with round-to-nearest-even or truncation.
module ieee754_divider #(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic        nan_o,
  output logic        inifinit_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        divzero_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DIV     = 3'd1,
    S_NORM    = 3'd2,
    S_SPECIAL = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_r;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [23:0]        mb_r;
  logic [25:0]        rem_r;
  logic [26:0]        q_r;
  logic [4:0]         cnt_r;
  logic [31:0]        pend_res_r;
  logic               pend_nan_r;
  logic               pend_inf_r;
  logic               pend_dz_r;

  logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic               special_s, sign_s;
  logic signed [9:0]  exp_diff_s;
  logic [31:0]        spec_res_s;
  logic               spec_nan_s, spec_inf_s, spec_dz_s;

  logic               ge_s;
  logic [25:0]        diff_s;
  logic [25:0]        rem_next_s;
  logic [26:0]        q_next_s;

  logic [22:0]        frac_s;
  logic               guard_s, sticky_s, round_s;
  logic [23:0]        frac_sum_s;
  logic signed [9:0]  e_pre_s, e_fin_s;
  logic [31:0]        norm_res_s;
  logic               norm_ovf_s, norm_unf_s;

  // Operand classification and special-case result for the operands at the inputs.
  always_comb begin
    a_zero_s   = (a_i[30:23] == 8'd0);
    b_zero_s   = (b_i[30:23] == 8'd0);
    a_inf_s    = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
    b_inf_s    = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);
    a_nan_s    = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
    b_nan_s    = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
    sign_s     = a_i[31] ^ b_i[31];
    special_s  = a_zero_s | b_zero_s | a_inf_s | b_inf_s | a_nan_s | b_nan_s;
    exp_diff_s = $signed({2'b00, a_i[30:23]}) - $signed({2'b00, b_i[30:23]}) + 10'sd127;
    spec_res_s = {sign_s, 31'd0};
    spec_nan_s = 1'b0;
    spec_inf_s = 1'b0;
    spec_dz_s  = 1'b0;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_res_s = 32'h7FC0_0000;
      spec_nan_s = 1'b1;
    end else if (a_inf_s) begin
      spec_res_s = {sign_s, 8'hFF, 23'd0};
      spec_inf_s = 1'b1;
    end else if (b_zero_s) begin
      spec_res_s = {sign_s, 8'hFF, 23'd0};
      spec_inf_s = 1'b1;
      spec_dz_s  = 1'b1;
    end else begin
      spec_res_s = {sign_s, 31'd0};
    end
  end

  // One restoring-division step; the remainder stays below twice the divisor.
  always_comb begin
    ge_s   = (rem_r >= {2'b00, mb_r});
    diff_s = rem_r - {2'b00, mb_r};
    if (ge_s) begin
      rem_next_s = diff_s << 1;
    end else begin
      rem_next_s = rem_r << 1;
    end
    q_next_s = {q_r[25:0], ge_s};
  end

  // Normalise, round and range-check the finished quotient.
  always_comb begin
    if (q_r[26]) begin
      frac_s   = q_r[25:3];
      guard_s  = q_r[2];
      sticky_s = (|q_r[1:0]) | (|rem_r);
      e_pre_s  = exp_r;
    end else begin
      frac_s   = q_r[24:2];
      guard_s  = q_r[1];
      sticky_s = q_r[0] | (|rem_r);
      e_pre_s  = exp_r - 10'sd1;
    end
    if (ROUND_NEAREST) begin
      round_s = guard_s & (sticky_s | frac_s[0]);
    end else begin
      round_s = 1'b0;
    end
    // A fraction carry-out means 1.11..1 rounded up to 2.0, i.e. 1.0 with exponent +1.
    frac_sum_s = {1'b0, frac_s} + {23'd0, round_s};
    e_fin_s    = e_pre_s + $signed({9'd0, frac_sum_s[23]});
    norm_ovf_s = 1'b0;
    norm_unf_s = 1'b0;
    if (e_fin_s >= 10'sd255) begin
      norm_res_s = {sign_r, 8'hFF, 23'd0};
      norm_ovf_s = 1'b1;
    end else if (e_fin_s <= 10'sd0) begin
      norm_res_s = {sign_r, 31'd0};
      norm_unf_s = 1'b1;
    end else begin
      norm_res_s = {sign_r, e_fin_s[7:0], frac_sum_s[22:0]};
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      sign_r      <= 1'b0;
      exp_r       <= 10'sd0;
      mb_r        <= 24'd0;
      rem_r       <= 26'd0;
      q_r         <= 27'd0;
      cnt_r       <= 5'd0;
      pend_res_r  <= 32'd0;
      pend_nan_r  <= 1'b0;
      pend_inf_r  <= 1'b0;
      pend_dz_r   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= 32'd0;
      nan_o       <= 1'b0;
      inifinit_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      divzero_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            sign_r     <= sign_s;
            exp_r      <= exp_diff_s;
            mb_r       <= {1'b1, b_i[22:0]};
            rem_r      <= {2'b01, a_i[22:0]};
            q_r        <= 27'd0;
            cnt_r      <= 5'd0;
            pend_res_r <= spec_res_s;
            pend_nan_r <= spec_nan_s;
            pend_inf_r <= spec_inf_s;
            pend_dz_r  <= spec_dz_s;
            busy_o     <= 1'b1;
            state_r    <= special_s ? S_SPECIAL : S_DIV;
          end else begin
            busy_o <= 1'b0;
          end
        end
        S_DIV: begin
          rem_r <= rem_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd26) begin
            state_r <= S_NORM;
          end else begin
            state_r <= S_DIV;
          end
        end
        S_NORM: begin
          quotient_o  <= norm_res_s;
          nan_o       <= 1'b0;
          inifinit_o  <= norm_ovf_s;
          overflow_o  <= norm_ovf_s;
          underflow_o <= norm_unf_s;
          divzero_o   <= 1'b0;
          state_r     <= S_DONE;
        end
        S_SPECIAL: begin
          quotient_o  <= pend_res_r;
          nan_o       <= pend_nan_r;
          inifinit_o  <= pend_inf_r;
          overflow_o  <= 1'b0;
          underflow_o <= 1'b0;
          divzero_o   <= pend_dz_r;
          state_r     <= S_DONE;
        end
        S_DONE: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ieee754_divider.sv
// Self-checking bench for ieee754_divider: vector table driven through a scoreboard
// queue, plus busy-start, mid-operation reset and truncation-mode sequences.
module tb_ieee754_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;

  logic        busy_o, done_o, nan_o, inf_o, ovf_o, unf_o, dz_o;
  logic [31:0] quotient_o;
  logic        busy_t, done_t, nan_t, inf_t, ovf_t, unf_t, dz_t;
  logic [31:0] quotient_t;

  ieee754_divider #(.ROUND_NEAREST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .a_i(a), .b_i(b), .start_i(start),
    .busy_o(busy_o), .done_o(done_o), .quotient_o(quotient_o),
    .nan_o(nan_o), .inifinit_o(inf_o), .overflow_o(ovf_o),
    .underflow_o(unf_o), .divzero_o(dz_o)
  );

  ieee754_divider #(.ROUND_NEAREST(1'b0)) dut_t (
    .clk(clk), .rst_n(rst_n), .a_i(a), .b_i(b), .start_i(start),
    .busy_o(busy_t), .done_o(done_t), .quotient_o(quotient_t),
    .nan_o(nan_t), .inifinit_o(inf_t), .overflow_o(ovf_t),
    .underflow_o(unf_t), .divzero_o(dz_t)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flags packed as {nan, inf, overflow, underflow, divzero}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] qt;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   acc_cyc = 0;
  int   done_cnt = 0;
  bit   in_flight = 1'b0;
  bit   busy_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] vq, input logic [31:0] vqt,
                              input logic [4:0] vfl, input int vlat);
    vec_t v;
    v.a = va; v.b = vb; v.q = vq; v.qt = vqt; v.fl = vfl; v.lat = vlat;
    return v;
  endfunction

  // Scoreboard: pop and compare whenever the DUT reports a result.
  always @(negedge clk) begin : monitor
    vec_t v;
    if (in_flight && !done_o && !busy_o) busy_bad = 1'b1;
    if (done_o) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        v = exp_q.pop_front();
        check("quotient", quotient_o, v.q);
        check("flags", {27'd0, nan_o, inf_o, ovf_o, unf_o, dz_o}, {27'd0, v.fl});
        check("latency", cyc - acc_cyc, v.lat);
        check("busy_during_op", {31'd0, busy_bad}, 32'd0);
        check("trunc_done", {31'd0, done_t}, 32'd1);
        check("trunc_quotient", quotient_t, v.qt);
        in_flight = 1'b0;
      end
    end
  end

  task automatic run_op(input vec_t v, input int extra_at);
    int d0;
    int k;
    d0 = done_cnt;
    @(negedge clk);
    a = v.a; b = v.b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
    busy_bad = 1'b0;
    in_flight = 1'b1;
    exp_q.push_back(v);
    k = 0;
    while (done_cnt == d0 && k < 60) begin
      @(negedge clk);
      #1;
      k++;
      if (k == extra_at) begin
        a = 32'h3F80_0000; b = 32'h4040_0000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      check("timeout", done_cnt - d0, 32'd1);
      exp_q.delete();
      in_flight = 1'b0;
    end
    @(negedge clk);
  endtask

  vec_t vecs[16];
  int   d1;

  initial begin
    vecs[0]  = mk(32'h4170_0000, 32'h4000_0000, 32'h40F0_0000, 32'h40F0_0000, 5'b00000, 29);
    vecs[1]  = mk(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 32'h3EAA_AAAA, 5'b00000, 29);
    vecs[2]  = mk(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 5'b01001, 2);
    vecs[3]  = mk(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 5'b10000, 2);
    vecs[4]  = mk(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 32'h7F80_0000, 5'b01100, 29);
    vecs[5]  = mk(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 5'b00010, 29);
    vecs[6]  = mk(32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 32'hC040_0000, 5'b00000, 29);
    vecs[7]  = mk(32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 32'h7F80_0000, 5'b01000, 2);
    vecs[8]  = mk(32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 5'b00000, 2);
    vecs[9]  = mk(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 5'b10000, 2);
    vecs[10] = mk(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 32'hFF80_0000, 5'b01001, 2);
    vecs[11] = mk(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 5'b10000, 2);
    vecs[12] = mk(32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 32'h8000_0000, 5'b00000, 2);
    vecs[13] = mk(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 5'b00000, 29);
    vecs[14] = mk(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 5'b00000, 2);
    vecs[15] = mk(32'h3F80_0000, 32'h3F7F_FFFF, 32'h3F80_0001, 32'h3F80_0000, 5'b00000, 29);

    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_quotient", quotient_o, 32'd0);
    check("reset_flags", {27'd0, nan_o, inf_o, ovf_o, unf_o, dz_o}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i], (i == 6) ? 5 : 0);
      if (i == 6) begin
        d1 = done_cnt;
        repeat (40) @(negedge clk);
        check("no_extra_done", done_cnt, d1);
        check("held_quotient", quotient_o, 32'hC040_0000);
      end
    end

    // Abort an operation with reset ten cycles into the division.
    run_op(vecs[6], 0);
    d1 = done_cnt;
    @(negedge clk);
    a = 32'h4170_0000; b = 32'h4000_0000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_done", {31'd0, done_o}, 32'd0);
    check("abort_quotient", quotient_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", done_cnt, d1);
    run_op(vecs[0], 0);
    run_op(vecs[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
